// File: rtl/text_console_ctrl.sv
// Character-stream console controller: turns printable codes and a few control
// codes into video-RAM writes, tracks the cursor and runs line/screen clears.
module text_console_ctrl #(
  parameter int COLS           = 80,
  parameter int ROWS           = 76,
  parameter int ADDR_WIDTH     = 13,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            char_in,
  input  logic                  char_valid,
  output logic                  char_ready,
  output logic [7:0]            ram_din,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [6:0]            cursor_col,
  output logic [6:0]            cursor_row,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, CLR_SCREEN, CLR_LINE} state_t;

  localparam state_t                RESET_STATE = (CLEAR_ON_RESET != 0) ? CLR_SCREEN : IDLE;
  localparam logic [ADDR_WIDTH-1:0] COLS_A      = ADDR_WIDTH'(COLS);
  localparam logic [ADDR_WIDTH-1:0] LINE_LAST   = ADDR_WIDTH'(COLS - 1);
  localparam logic [ADDR_WIDTH-1:0] SCREEN_LAST = ADDR_WIDTH'(COLS * ROWS - 1);
  localparam logic [6:0]            COL_LAST    = 7'(COLS - 1);
  localparam logic [6:0]            ROW_LAST    = 7'(ROWS - 1);
  localparam logic [7:0]            SPACE       = 8'h20;

  state_t                  state, state_d;
  logic [6:0]              col_d, row_d;
  logic [ADDR_WIDTH-1:0]   row_base, base_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt, cnt_d;
  logic [7:0]              din_d;
  logic                    we_d;
  logic [ADDR_WIDTH-1:0]   waddr_d;

  assign char_ready = (state == IDLE);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RESET_STATE;
      cursor_col <= '0;
      cursor_row <= '0;
      row_base   <= '0;
      clr_cnt    <= '0;
      ram_we     <= 1'b0;
      ram_din    <= 8'h00;
      ram_waddr  <= '0;
    end else begin
      state      <= state_d;
      cursor_col <= col_d;
      cursor_row <= row_d;
      row_base   <= base_d;
      clr_cnt    <= cnt_d;
      ram_we     <= we_d;
      ram_din    <= din_d;
      ram_waddr  <= waddr_d;
    end
  end

  always_comb begin
    state_d = state;
    col_d   = cursor_col;
    row_d   = cursor_row;
    base_d  = row_base;
    cnt_d   = clr_cnt;
    we_d    = 1'b0;
    din_d   = ram_din;
    waddr_d = ram_waddr;
    unique case (state)
      IDLE: begin
        if (char_valid) begin
          unique case (char_in)
            8'h08: if (cursor_col != 7'd0) col_d = cursor_col - 7'd1;
            8'h0D: col_d = '0;
            8'h0C: begin
              state_d = CLR_SCREEN;
              cnt_d   = '0;
            end
            default: begin
              // Printable: written at the old cursor; LF shares the newline path below.
              if (char_in != 8'h0A) begin
                we_d    = 1'b1;
                din_d   = char_in;
                waddr_d = row_base + ADDR_WIDTH'(cursor_col);
              end
              if (char_in == 8'h0A || cursor_col == COL_LAST) begin
                col_d   = '0;
                state_d = CLR_LINE;
                cnt_d   = '0;
                if (cursor_row == ROW_LAST) begin
                  row_d  = '0;
                  base_d = '0;
                end else begin
                  row_d  = cursor_row + 7'd1;
                  base_d = row_base + COLS_A;
                end
              end else begin
                col_d = cursor_col + 7'd1;
              end
            end
          endcase
        end
      end
      CLR_SCREEN: begin
        we_d    = 1'b1;
        din_d   = SPACE;
        waddr_d = clr_cnt;
        cnt_d   = clr_cnt + 1'b1;
        if (clr_cnt == SCREEN_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          col_d   = '0;
          row_d   = '0;
          base_d  = '0;
        end
      end
      CLR_LINE: begin
        we_d    = 1'b1;
        din_d   = SPACE;
        waddr_d = row_base + clr_cnt;
        cnt_d   = clr_cnt + 1'b1;
        if (clr_cnt == LINE_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Randomized bench for text_console_ctrl: a screen-level model predicts every
// RAM write and cursor position; a monitor collects the writes actually made.
module tb_text_console_ctrl;
  localparam int COLS = 80;
  localparam int ROWS = 76;
  localparam int AW   = 13;
  localparam int LIMIT = 10000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    char_in = 8'h00;
  logic          char_valid = 1'b0;
  logic          char_ready;
  logic [7:0]    ram_din;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [6:0]    cursor_col, cursor_row;
  logic          busy;

  text_console_ctrl #(.COLS(COLS), .ROWS(ROWS), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst(rst), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .ram_din(ram_din), .ram_we(ram_we),
    .ram_waddr(ram_waddr), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  logic [AW+7:0] obs_q[$];
  logic [AW+7:0] exp_q[$];
  int mcol = 0;
  int mrow = 0;

  always @(negedge clk) if (ram_we === 1'b1) obs_q.push_back({ram_waddr, ram_din});

  // ---------------- reference model ----------------
  function automatic void model_clear_screen();
    for (int a = 0; a < COLS * ROWS; a++) exp_q.push_back({AW'(a), 8'h20});
    mrow = 0;
    mcol = 0;
  endfunction

  function automatic void model_newline();
    mcol = 0;
    mrow = (mrow + 1) % ROWS;
    for (int i = 0; i < COLS; i++) exp_q.push_back({AW'(mrow * COLS + i), 8'h20});
  endfunction

  function automatic void model_char(input logic [7:0] c);
    case (c)
      8'h08: if (mcol > 0) mcol--;
      8'h0D: mcol = 0;
      8'h0A: model_newline();
      8'h0C: model_clear_screen();
      default: begin
        exp_q.push_back({AW'(mrow * COLS + mcol), c});
        if (mcol == COLS - 1) model_newline();
        else mcol++;
      end
    endcase
  endfunction

  // ---------------- drivers ----------------
  // Entered and left on a falling edge; junk strobes are offered while busy.
  task automatic send(input logic [7:0] c, input bit junk);
    int guard = 0;
    while (char_ready !== 1'b1 && guard < LIMIT) begin
      char_valid = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      char_in    = 8'($urandom);
      guard++;
      @(negedge clk);
    end
    if (guard >= LIMIT) begin
      vecs++; errs++;
      $display("FAIL send_timeout: char_ready stuck at %b, required 1", char_ready);
    end
    char_in    = c;
    char_valid = 1'b1;
    model_char(c);
    @(negedge clk);
    char_valid = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < LIMIT) begin
      cyc++;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic goto_row(input int r);
    while (mrow != r) send(8'h0A, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int cyc;
    rst = 1'b1;
    @(negedge clk);
    vecs++;
    if ({ram_we, ram_din, ram_waddr, cursor_col, cursor_row, busy, char_ready} !==
        {1'b0, 8'h00, AW'(0), 7'd0, 7'd0, 1'b1, 1'b0}) begin
      errs++;
      $display("FAIL reset_outputs: we=%b din=%h addr=%0d col=%0d row=%0d busy=%b rdy=%b, required 0 00 0 0 0 1 0",
               ram_we, ram_din, ram_waddr, cursor_col, cursor_row, busy, char_ready);
    end
    obs_q.delete(); exp_q.delete();
    model_clear_screen();
    rst = 1'b0;
    wait_idle(cyc);
    vecs++;
    if (cyc != COLS * ROWS) begin
      errs++; $display("FAIL reset_busy_cycles: got %0d, required %0d", cyc, COLS * ROWS);
    end
    vecs++;
    if ({char_ready, cursor_row, cursor_col} !== {1'b1, 7'd0, 7'd0}) begin
      errs++; $display("FAIL reset_end_state: rdy=%b row=%0d col=%0d, required 1 0 0", char_ready, cursor_row, cursor_col);
    end
    vecs++;
    if (obs_q.size() != exp_q.size()) begin
      errs++; $display("FAIL reset_write_count: got %0d, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vecs++;
      if (obs_q[i] !== exp_q[i]) begin
        errs++; $display("FAIL reset_write[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]); break;
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_single_char();
    int cyc;
    send(8'h41, 1'b0);
    vecs++;
    if ({ram_we, ram_waddr, ram_din, cursor_row, cursor_col} !== {1'b1, AW'(0), 8'h41, 7'd0, 7'd1}) begin
      errs++;
      $display("FAIL char_A: we=%b addr=%0d din=%h row=%0d col=%0d, required 1 0 41 0 1",
               ram_we, ram_waddr, ram_din, cursor_row, cursor_col);
    end
    @(negedge clk);
    vecs++;
    if (ram_we !== 1'b0 || ram_din !== 8'h41 || ram_waddr !== AW'(0)) begin
      errs++; $display("FAIL char_A_hold: we=%b din=%h addr=%0d, required 0 41 0", ram_we, ram_din, ram_waddr);
    end
    wait_idle(cyc);
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_line_wrap();
    int cyc;
    send(8'h0D, 1'b0);
    goto_row(2);
    wait_idle(cyc);
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < COLS; i++) send(8'($urandom_range(32, 126)), 1'b0);
    wait_idle(cyc);
    vecs++;
    if (cyc != COLS) begin
      errs++; $display("FAIL wrap_busy_cycles: got %0d, required %0d", cyc, COLS);
    end
    vecs++;
    if (cursor_row !== 7'd3 || cursor_col !== 7'd0) begin
      errs++; $display("FAIL wrap_cursor: row=%0d col=%0d, required 3 0", cursor_row, cursor_col);
    end
    vecs++;
    if (obs_q.size() != 2 * COLS || obs_q[COLS-1][AW+7:8] !== AW'(239) || obs_q[COLS][AW+7:8] !== AW'(240)) begin
      errs++; $display("FAIL wrap_boundary: writes=%0d, required %0d with last char at 239 then clear from 240", obs_q.size(), 2 * COLS);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vecs++;
      if (obs_q[i] !== exp_q[i]) begin
        errs++; $display("FAIL wrap_write[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]); break;
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_bottom_wrap();
    int cyc;
    goto_row(ROWS - 1);
    wait_idle(cyc);
    obs_q.delete(); exp_q.delete();
    send(8'h0A, 1'b0);
    wait_idle(cyc);
    vecs++;
    if (cursor_row !== 7'd0 || cursor_col !== 7'd0 || obs_q.size() != COLS) begin
      errs++; $display("FAIL lf_wrap: row=%0d col=%0d writes=%0d, required 0 0 %0d", cursor_row, cursor_col, obs_q.size(), COLS);
    end
    goto_row(ROWS - 1);
    for (int i = 0; i < COLS; i++) send(8'($urandom_range(32, 126)), 1'b1);
    wait_idle(cyc);
    vecs++;
    if (obs_q.size() != exp_q.size()) begin
      errs++; $display("FAIL bottom_write_count: got %0d, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vecs++;
      if (obs_q[i] !== exp_q[i]) begin
        errs++; $display("FAIL bottom_write[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]); break;
      end
    end
    vecs++;
    if (cursor_row !== 7'd0 || cursor_col !== 7'd0) begin
      errs++; $display("FAIL bottom_cursor: row=%0d col=%0d, required 0 0", cursor_row, cursor_col);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_bs_cr();
    int cyc;
    send(8'h08, 1'b0);
    @(negedge clk);
    vecs++;
    if (obs_q.size() != 0 || cursor_col !== 7'd0 || cursor_row !== 7'd0) begin
      errs++; $display("FAIL bs_col0: writes=%0d row=%0d col=%0d, required 0 0 0", obs_q.size(), cursor_row, cursor_col);
    end
    goto_row(5);
    for (int i = 0; i < 40; i++) send(8'($urandom_range(32, 126)), 1'b0);
    wait_idle(cyc);
    obs_q.delete(); exp_q.delete();
    vecs++;
    if (cursor_row !== 7'd5 || cursor_col !== 7'd40) begin
      errs++; $display("FAIL pre_cr_cursor: row=%0d col=%0d, required 5 40", cursor_row, cursor_col);
    end
    send(8'h0D, 1'b0);
    @(negedge clk);
    vecs++;
    if (obs_q.size() != 0 || cursor_row !== 7'd5 || cursor_col !== 7'd0 || char_ready !== 1'b1) begin
      errs++; $display("FAIL cr: writes=%0d row=%0d col=%0d rdy=%b, required 0 5 0 1", obs_q.size(), cursor_row, cursor_col, char_ready);
    end
  endtask

  task automatic test_random();
    int cyc;
    int r;
    logic [7:0] c;
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 199);
      if (r < 1)       c = 8'h0C;
      else if (r < 20) c = 8'h0A;
      else if (r < 32) c = 8'h0D;
      else if (r < 50) c = 8'h08;
      else begin
        c = 8'($urandom);
        if (c == 8'h08 || c == 8'h0A || c == 8'h0C || c == 8'h0D) c = 8'h7E;
      end
      send(c, 1'b1);
    end
    wait_idle(cyc);
    vecs++;
    if (cursor_row !== 7'(mrow) || cursor_col !== 7'(mcol)) begin
      errs++; $display("FAIL random_cursor: row=%0d col=%0d, required %0d %0d", cursor_row, cursor_col, mrow, mcol);
    end
    vecs++;
    if (obs_q.size() != exp_q.size()) begin
      errs++; $display("FAIL random_write_count: got %0d, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vecs++;
      if (obs_q[i] !== exp_q[i]) begin
        errs++; $display("FAIL random_write[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]); break;
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_rst_mid_line();
    int cyc;
    send(8'h0A, 1'b0);
    repeat (10) @(negedge clk);
    vecs++;
    if (busy !== 1'b1) begin
      errs++; $display("FAIL mid_line_busy: got %b, required 1", busy);
    end
    #2 rst = 1'b1;
    #1;
    vecs++;
    if ({ram_we, ram_din, ram_waddr, cursor_col, cursor_row, busy, char_ready} !==
        {1'b0, 8'h00, AW'(0), 7'd0, 7'd0, 1'b1, 1'b0}) begin
      errs++;
      $display("FAIL mid_rst_outputs: we=%b din=%h addr=%0d col=%0d row=%0d busy=%b rdy=%b, required 0 00 0 0 0 1 0",
               ram_we, ram_din, ram_waddr, cursor_col, cursor_row, busy, char_ready);
    end
    @(negedge clk);
    @(negedge clk);
    obs_q.delete(); exp_q.delete();
    model_clear_screen();
    rst = 1'b0;
    wait_idle(cyc);
    vecs++;
    if (cyc != COLS * ROWS || obs_q.size() != exp_q.size()) begin
      errs++; $display("FAIL mid_rst_clear: busy=%0d writes=%0d, required %0d %0d", cyc, obs_q.size(), COLS * ROWS, exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vecs++;
      if (obs_q[i] !== exp_q[i]) begin
        errs++; $display("FAIL mid_rst_write[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]); break;
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_char();
    test_line_wrap();
    test_bottom_wrap();
    test_bs_cr();
    test_random();
    test_rst_mid_line();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
